whackamole_engine: RTL

Parametrised, self-contained game engine for the whack-a-mole ASIC. It generalises the single-mode round controller: N selectable targets, a multi-life budget, an interval that shrinks per hit down to a programmable floor, and explicit start/restart control. It sits between the user input debouncer and the display/score drivers. It owns target generation, the round timer, scoring and game-over.

---
 rtl/whackamole_pkg.sv | 15 +
 rtl/whackamole_engine_lfsr.sv | 28 ++
 rtl/whackamole_engine.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/whackamole_pkg.sv
// Shared definitions for the whack-a-mole game engine: FSM states and LFSR constants.
package whackamole_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PICK,
      ST_SHOW,
      ST_DELAY,
      ST_OVER
   } state_t;

   localparam logic [15:0] LFSR_MASK    = 16'hB400;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/whackamole_engine_lfsr.sv
// Free-running Galois LFSR; never reaches zero from a non-zero seed.
module game_lfsr
   import whackamole_pkg::*;
#(
   parameter int unsigned        WIDTH = 16,
   parameter logic [WIDTH-1:0]   SEED  = WIDTH'(DEFAULT_SEED),
   parameter logic [WIDTH-1:0]   MASK  = WIDTH'(LFSR_MASK),
   parameter int unsigned        OUT_W = WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   output logic [OUT_W-1:0] value
);

   logic [WIDTH-1:0] state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= SEED;
      end else begin
         state <= (state >> 1) ^ (state[0] ? MASK : '0);
      end
   end

   // Only the low bits are consumed downstream.
   assign value = state[OUT_W-1:0];

endmodule

// File: rtl/whackamole_engine.sv
// Whack-a-mole game engine: target generation, response window, scoring, lives and game-over.
module whackamole_engine
   import whackamole_pkg::*;
#(
   parameter int unsigned N_TARGETS         = 16,
   parameter int unsigned TGT_W             = 4,
   parameter int unsigned INIT_INTERVAL_CYC = 300_000,
   parameter int unsigned DESC_CYC          = 100_000,
   parameter int unsigned MIN_INTERVAL_CYC  = 50_000,
   parameter int unsigned NEXT_DELAY_CYC    = 5_000,
   parameter int unsigned LIVES             = 3,
   parameter int unsigned PTS_W             = 32,
   parameter logic [15:0] SEED              = DEFAULT_SEED
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         user_valid,
   input  logic [TGT_W-1:0]             user_number,
   output logic [TGT_W-1:0]             target_number,
   output logic                         target_valid,
   output logic [PTS_W-1:0]             pts_counter,
   output logic [$clog2(LIVES+1)-1:0]   lives_left,
   output logic [7:0]                   level,
   output logic                         hit,
   output logic                         miss,
   output logic                         game_over
);

   localparam int unsigned      LW         = $clog2(LIVES + 1);
   localparam logic [31:0]      INIT_I     = 32'(INIT_INTERVAL_CYC);
   localparam logic [31:0]      DESC_I     = 32'(DESC_CYC);
   localparam logic [31:0]      MIN_I      = 32'(MIN_INTERVAL_CYC);
   localparam logic [31:0]      DELAY_I    = 32'(NEXT_DELAY_CYC);
   localparam logic [LW-1:0]    LIVES_INIT = LW'(LIVES);
   localparam logic [TGT_W:0]   N_LIM      = (TGT_W + 1)'(N_TARGETS);

   state_t             state, state_n;
   logic [31:0]        timer, timer_n;
   logic [31:0]        interval, interval_n;
   logic               have_prev, have_prev_n;
   logic [TGT_W-1:0]   target_n;
   logic [PTS_W-1:0]   pts_n;
   logic [LW-1:0]      lives_n;
   logic [7:0]         level_n;
   logic               hit_n, miss_n;

   logic [TGT_W-1:0]   cand;
   logic               cand_ok;
   logic               correct;
   logic               expire;

   game_lfsr #(
      .WIDTH (16),
      .SEED  (SEED),
      .MASK  (LFSR_MASK),
      .OUT_W (TGT_W)
   ) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .value (cand)
   );

   assign cand_ok = ({1'b0, cand} < N_LIM) && !(have_prev && (cand == target_number));
   assign correct = user_valid && (user_number == target_number);
   assign expire  = (timer == 32'd1);

   always_comb begin
      state_n     = state;
      timer_n     = timer;
      interval_n  = interval;
      have_prev_n = have_prev;
      target_n    = target_number;
      pts_n       = pts_counter;
      lives_n     = lives_left;
      level_n     = level;
      hit_n       = 1'b0;
      miss_n      = 1'b0;

      case (state)
         ST_IDLE, ST_OVER: begin
            if (start) begin
               pts_n      = '0;
               level_n    = '0;
               lives_n    = LIVES_INIT;
               interval_n = INIT_I;
               state_n    = ST_PICK;
            end
         end
         ST_PICK: begin
            if (cand_ok) begin
               target_n    = cand;
               have_prev_n = 1'b1;
               timer_n     = interval;
               state_n     = ST_SHOW;
            end
         end
         ST_SHOW: begin
            // A correct guess wins over a timeout in the same cycle.
            if (correct) begin
               hit_n      = 1'b1;
               pts_n      = pts_counter + PTS_W'(1);
               level_n    = (level == 8'hFF) ? level : level + 8'd1;
               interval_n = ((interval - MIN_I) > DESC_I) ? interval - DESC_I : MIN_I;
               timer_n    = DELAY_I;
               state_n    = ST_DELAY;
            end else if (user_valid || expire) begin
               miss_n  = 1'b1;
               lives_n = lives_left - LW'(1);
               if (lives_left == LW'(1)) begin
                  state_n = ST_OVER;
               end else if (expire) begin
                  timer_n = DELAY_I;
                  state_n = ST_DELAY;
               end else begin
                  timer_n = timer - 32'd1;
               end
            end else begin
               timer_n = timer - 32'd1;
            end
         end
         ST_DELAY: begin
            if (expire) begin
               state_n = ST_PICK;
            end else begin
               timer_n = timer - 32'd1;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         timer         <= '0;
         interval      <= INIT_I;
         have_prev     <= 1'b0;
         target_number <= '0;
         pts_counter   <= '0;
         lives_left    <= LIVES_INIT;
         level         <= '0;
         hit           <= 1'b0;
         miss          <= 1'b0;
      end else begin
         state         <= state_n;
         timer         <= timer_n;
         interval      <= interval_n;
         have_prev     <= have_prev_n;
         target_number <= target_n;
         pts_counter   <= pts_n;
         lives_left    <= lives_n;
         level         <= level_n;
         hit           <= hit_n;
         miss          <= miss_n;
      end
   end

   assign target_valid = (state == ST_SHOW);
   assign game_over    = (state == ST_OVER);

endmodule
